// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame length and common
// keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        WAIT_IDLE
    } ps2_tx_state_e;

    // Device falling edges in one host-to-device frame: 8 data, parity, stop, ack.
    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// PS/2 pad synchronizers: 3-flop clock chain with falling-edge detect and a
// 2-flop data chain. Usable by both the host transmitter and the receiver.
module ps2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic fe
);

    logic [2:0] clk_pipe;
    logic [1:0] data_pipe;

    // Idle bus is high, so reset the chains high to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
        end else begin
            clk_pipe  <= {clk_pipe[1:0], ps2_clk};
            data_pipe <= {data_pipe[0], ps2_data};
        end
    end

    assign clk_s  = clk_pipe[1];
    assign data_s = data_pipe[1];
    assign fe     = clk_pipe[2] & ~clk_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, RTS, 11-edge frame, ACK).
// Define PS2_TX_TIMEOUT_EN to add the ps2_clk watchdog on XFER/WAIT_IDLE.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    ps2_tx_state_e state, state_nxt;
    logic [IW-1:0] inh_cnt;
    logic [8:0]    shift;
    logic [3:0]    bit_cnt;
    logic          data_bit;
    logic          nack;
    logic          clk_s, data_s, fe;
    logic          to_hit;

    ps2_edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .clk_s   (clk_s),
        .data_s  (data_s),
        .fe      (fe)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == RTS || fe)
            to_cnt <= '0;
        else if (state == XFER || state == WAIT_IDLE)
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state == XFER || state == WAIT_IDLE) && !fe &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build; the comparison is constant false.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (tx_valid) state_nxt = INHIBIT;
            INHIBIT:   if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nxt = RTS;
            RTS:       state_nxt = XFER;
            XFER:      if (fe && bit_cnt == 4'(FRAME_EDGES - 1)) state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (clk_s && data_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (to_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cnt  <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            data_bit <= 1'b0;
            nack     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (tx_valid) begin
                    shift   <= {odd_parity(tx_data), tx_data};
                    bit_cnt <= '0;
                    inh_cnt <= '0;
                    nack    <= 1'b0;
                end
                INHIBIT: inh_cnt <= inh_cnt + 1'b1;
                RTS:     data_bit <= 1'b1;  // start bit held until the first device edge
                XFER: if (fe) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt < 4'd9) begin
                        data_bit <= ~shift[0];
                        shift    <= {1'b0, shift[8:1]};
                    end else if (bit_cnt == 4'd9) begin
                        data_bit <= 1'b0;
                    end else begin
                        nack <= data_s;
                    end
                end
                default: ;
            endcase
            if (to_hit) begin
                done     <= 1'b1;
                err      <= 1'b1;
                data_bit <= 1'b0;
            end else if (state == WAIT_IDLE && state_nxt == IDLE) begin
                done <= 1'b1;
                err  <= nack;
            end
        end
    end

    assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
    assign ps2_data_oe = (state == RTS) || (state == XFER && data_bit);
    assign tx_ready    = (state == IDLE);
    assign tx_busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 2000;
    localparam int TO   = 1500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       tx_ready, tx_busy, done, err;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        logic       err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for RTS, clock n_edges falls, sample host data on rises.
    task automatic dev_frame(input logic ack, input int n_edges, output logic [9:0] bits);
        int t = 0;
        bits = '0;
        while (!(!ps2_clk_oe && ps2_data_oe) && t < INH + 100) begin
            tick(1);
            t++;
        end
        check("rts_seen", {31'd0, (t < INH + 100)}, 32'd1);
        tick(50);
        for (int i = 0; i < n_edges; i++) begin
            if (i == 10 && ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = ps2_data;
            if (i < 10) tick(HALF);
        end
        if (n_edges == 11 && ack) tick(2);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(output logic got);
        int n = 0;
        got = 1'b0;
        while (n < 200) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick(1);
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[4];
        logic [9:0] bits;
        logic       got;
        int         n;
        logic       seen;

        tbl[0] = '{CMD_SET_LED, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h01,       1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h55,       1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h80,       1'b1, 1'b0, 1'b0};

        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_oe",    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("reset_ready", {30'd0, tx_ready, tx_busy}, 32'd2);
        check("reset_done",  {30'd0, done, err}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].data);
            n = 0;
            while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
                n++;
                tick(1);
            end
            check("inhibit_len", n, INH);
            check("rts_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
            tick(1);
            check("xfer_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
            dev_frame(tbl[i].ack, 11, bits);
            check("frame_bits", {22'd0, bits}, {22'd0, 1'b1, tbl[i].par, tbl[i].data});
            wait_done(got);
            check("done", {31'd0, got}, 32'd1);
            check("err", {31'd0, err}, {31'd0, tbl[i].err});
            check("end_oe", {29'd0, ps2_clk_oe, ps2_data_oe, tx_ready}, 32'd1);
            tick(3);
            check("err_held", {30'd0, err, done}, {30'd0, tbl[i].err, 1'b0});
        end

`ifdef PS2_TX_TIMEOUT_EN
        // Device never clocks: watchdog fires TO cycles after XFER entry.
        send(CMD_ENABLE);
        n = 0;
        while (ps2_clk_oe && n < INH + 10) begin
            n++;
            tick(1);
        end
        n = 0;
        while (!done && n < TO + 10) begin
            tick(1);
            n++;
        end
        check("timeout_len", n, TO);
        check("timeout_err", {29'd0, err, ps2_clk_oe, ps2_data_oe}, 32'd4);
        tick(3);
`endif

        // Reset after the 4th device edge aborts cleanly.
        send(CMD_ENABLE);
        dev_frame(1'b1, 4, bits);
        rst = 1'b1;
        tick(1);
        check("rst_abort", {28'd0, ps2_clk_oe, ps2_data_oe, tx_ready, done}, 32'd2);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) seen = 1'b1;
            tick(1);
        end
        check("rst_no_done", {31'd0, seen}, 32'd0);
        send(CMD_ENABLE);
        dev_frame(1'b1, 11, bits);
        check("f4_bits", {22'd0, bits}, {22'd0, 2'b10, 8'hF4});
        wait_done(got);
        check("f4_done_err", {30'd0, got, err}, 32'd2);
        tick(3);

        // tx_valid held across a transfer: re-accepted in the done cycle.
        tx_data  = CMD_RESET;
        tx_valid = 1'b1;
        tick(1);
        check("b2b_busy", {30'd0, tx_ready, tx_busy}, 32'd1);
        dev_frame(1'b1, 11, bits);
        check("ff_bits", {22'd0, bits}, {22'd0, 2'b11, 8'hFF});
        wait_done(got);
        check("b2b_done", {29'd0, got, err, tx_ready}, 32'd5);
        tick(1);
        tx_valid = 1'b0;
        check("b2b_inhibit", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd5);
        dev_frame(1'b1, 11, bits);
        check("ff2_bits", {22'd0, bits}, {22'd0, 2'b11, 8'hFF});
        wait_done(got);
        check("ff2_done_err", {30'd0, got, err}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
